// File: rtl/sram_1rw1r_sync.sv
// Parametrised single-clock 1RW+1R synchronous SRAM with masked writes, 1/2-cycle read
// latency, selectable port-0-write / port-1-read collision policy and optional post-reset clear.
module sram_1rw1r_sync #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned NUM_WMASKS     = 4,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned COLLISION_MODE = 0,
  parameter int unsigned INIT_EN        = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic                  init_busy_o,
  input  logic                  csb0_i,
  input  logic                  web0_i,
  input  logic [NUM_WMASKS-1:0] wmask0_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [DATA_WIDTH-1:0] din0_i,
  output logic [DATA_WIDTH-1:0] dout0_o,
  output logic                  rvalid0_o,
  input  logic                  csb1_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  output logic [DATA_WIDTH-1:0] dout1_o,
  output logic                  rvalid1_o,
  output logic                  collision_o
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned LANE_W = DATA_WIDTH / NUM_WMASKS;

  if (DATA_WIDTH % NUM_WMASKS != 0) begin : g_bad_mask
    $fatal(1, "DATA_WIDTH must be a multiple of NUM_WMASKS");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $fatal(1, "READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] init_addr_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  ready, wr0, rd0, rd1, coll;
  logic [DATA_WIDTH-1:0] wr_word, rd0_word, rd1_word;

  always_comb begin
    ready    = (state_q == ST_READY) && !rst_i;
    wr0      = ready && !csb0_i && !web0_i;
    rd0      = ready && !csb0_i && web0_i;
    rd1      = ready && !csb1_i;
    coll     = wr0 && rd1 && (addr0_i == addr1_i);
    wr_word  = mem_q[addr0_i];
    for (int unsigned i = 0; i < NUM_WMASKS; i++) begin
      if (wmask0_i[i]) wr_word[i*LANE_W +: LANE_W] = din0_i[i*LANE_W +: LANE_W];
    end
    rd0_word = mem_q[addr0_i];
    // Write-through hands port 1 the merged word being written on this same edge
    rd1_word = (coll && COLLISION_MODE == 0) ? wr_word : mem_q[addr1_i];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == ST_INIT) mem_q[init_addr_q] <= INIT_VALUE;
      else if (wr0)           mem_q[addr0_i]     <= wr_word;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= (INIT_EN != 0) ? ST_INIT : ST_READY;
      init_addr_q <= '0;
      busy_q      <= (INIT_EN != 0);
    end else if (state_q == ST_INIT) begin
      init_addr_q <= init_addr_q + 1'b1;
      if (&init_addr_q) begin
        state_q <= ST_READY;
        busy_q  <= 1'b0;
      end
    end
  end

  logic                  rvalid0_d, rvalid1_d;
  logic [DATA_WIDTH-1:0] dout0_d, dout1_d;

  if (READ_LATENCY == 2) begin : g_pipe
    logic                  p0_vld_q, p1_vld_q;
    logic [DATA_WIDTH-1:0] p0_data_q, p1_data_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        p0_vld_q  <= 1'b0;
        p1_vld_q  <= 1'b0;
        p0_data_q <= '0;
        p1_data_q <= '0;
      end else begin
        p0_vld_q <= rd0;
        p1_vld_q <= rd1;
        if (rd0) p0_data_q <= rd0_word;
        if (rd1) p1_data_q <= rd1_word;
      end
    end

    assign rvalid0_d = p0_vld_q;
    assign rvalid1_d = p1_vld_q;
    assign dout0_d   = p0_data_q;
    assign dout1_d   = p1_data_q;
  end else begin : g_direct
    assign rvalid0_d = rd0;
    assign rvalid1_d = rd1;
    assign dout0_d   = rd0_word;
    assign dout1_d   = rd1_word;
  end

  logic                  rvalid0_q, rvalid1_q, coll_q;
  logic [DATA_WIDTH-1:0] dout0_q, dout1_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      coll_q    <= 1'b0;
      dout0_q   <= '0;
      dout1_q   <= '0;
    end else begin
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      coll_q    <= coll;
      if (rvalid0_d) dout0_q <= dout0_d;
      if (rvalid1_d) dout1_q <= dout1_d;
    end
  end

  assign init_busy_o = busy_q;
  assign dout0_o     = dout0_q;
  assign dout1_o     = dout1_q;
  assign rvalid0_o   = rvalid0_q;
  assign rvalid1_o   = rvalid1_q;
  assign collision_o = coll_q;

endmodule

// File: tb/tb_sram_1rw1r_sync.sv
// Scoreboard bench: two SRAM configurations share one random/directed stimulus stream and are
// checked against an array-based reference model of the memory behaviour.
module tb_sram_1rw1r_sync;

  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam logic [31:0] INIT_A = 32'hCAFEF00D;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, csb0 = 1'b1, web0 = 1'b1, csb1 = 1'b1;
  logic [3:0]  wmask0 = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [31:0] din0 = '0;

  logic [31:0] dout0_a, dout1_a, dout0_b, dout1_b;
  logic        rv0_a, rv1_a, rv0_b, rv1_b, busy_a, busy_b, coll_a, coll_b;

  // Instance A: latency 2, write-through, cleared to INIT_A after reset
  sram_1rw1r_sync #(
    .DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_WMASKS(4), .READ_LATENCY(2),
    .COLLISION_MODE(0), .INIT_EN(1), .INIT_VALUE(INIT_A)
  ) dut_a (
    .clk_i(clk), .rst_i(rst), .init_busy_o(busy_a),
    .csb0_i(csb0), .web0_i(web0), .wmask0_i(wmask0), .addr0_i(addr0), .din0_i(din0),
    .dout0_o(dout0_a), .rvalid0_o(rv0_a),
    .csb1_i(csb1), .addr1_i(addr1), .dout1_o(dout1_a), .rvalid1_o(rv1_a),
    .collision_o(coll_a)
  );

  // Instance B: latency 1, read-first, array untouched by reset
  sram_1rw1r_sync #(
    .DATA_WIDTH(32), .ADDR_WIDTH(AW), .NUM_WMASKS(4), .READ_LATENCY(1),
    .COLLISION_MODE(1), .INIT_EN(0), .INIT_VALUE(32'h0)
  ) dut_b (
    .clk_i(clk), .rst_i(rst), .init_busy_o(busy_b),
    .csb0_i(csb0), .web0_i(web0), .wmask0_i(wmask0), .addr0_i(addr0), .din0_i(din0),
    .dout0_o(dout0_b), .rvalid0_o(rv0_b),
    .csb1_i(csb1), .addr1_i(addr1), .dout1_o(dout1_b), .rvalid1_o(rv1_b),
    .collision_o(coll_b)
  );

  typedef struct {
    int          port;   // 0=A0 1=A1 2=B0 3=B1
    logic [31:0] data;
    bit          dc;     // word never written: data not checked
    int          due;    // edge index after which rvalid must be seen
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m   [2][DEPTH];
  bit          known_m [2][DEPTH];
  int          init_left [2] = '{0, 0};
  bit          coll_exp [int];
  bit          busy_exp [int];
  bit          rst_edge [int];

  int edges = 0;
  int errors = 0;
  int checks = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edges);
    end
  endtask

  // Reference model: applies the requests currently on the inputs to the upcoming edge
  task automatic model_edge();
    int e, lat, md, a;
    logic [31:0] nw;
    bit nk, wr, r0, r1, c;
    e = edges + 1;
    for (int k = 0; k < 2; k++) begin
      lat = (k == 0) ? 2 : 1;
      md  = (k == 0) ? 0 : 1;
      if (rst) begin
        init_left[k] = (k == 0) ? DEPTH : 0;
        rst_edge[e] = 1'b1;
      end else if (init_left[k] > 0) begin
        a = DEPTH - init_left[k];
        mem_m[k][a]   = INIT_A;
        known_m[k][a] = 1'b1;
        init_left[k]--;
      end else begin
        wr = !csb0 && !web0;
        r0 = !csb0 && web0;
        r1 = !csb1;
        nw = mem_m[k][addr0];
        nk = known_m[k][addr0] || (wmask0 == 4'hF);
        for (int l = 0; l < 4; l++) if (wmask0[l]) nw[8*l +: 8] = din0[8*l +: 8];
        c = wr && r1 && (addr0 == addr1);
        if (r0) sb.push_back('{port: k*2, data: mem_m[k][addr0], dc: !known_m[k][addr0], due: e+lat-1});
        if (r1) begin
          if (c && md == 0) sb.push_back('{port: k*2+1, data: nw, dc: !nk, due: e+lat-1});
          else sb.push_back('{port: k*2+1, data: mem_m[k][addr1], dc: !known_m[k][addr1], due: e+lat-1});
        end
        if (c) coll_exp[e*2+k] = 1'b1;
        if (wr) begin
          mem_m[k][addr0]   = nw;
          known_m[k][addr0] = nk;
        end
      end
      busy_exp[e*2+k] = (init_left[k] > 0);
    end
  endtask

  task automatic drive(input bit r, input bit c0, input bit w0, input logic [3:0] m,
                       input logic [3:0] a0, input logic [31:0] d, input bit c1, input logic [3:0] a1);
    rst = r; csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0);
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents read data
  logic [31:0] last_m  [4] = '{default: '0};
  bit          lastk_m [4] = '{default: 1'b0};
  always @(negedge clk) begin : mon
    logic [31:0] dw [4];
    logic        rw [4];
    int n, idx;
    string nm;
    n = edges;
    dw[0] = dout0_a; dw[1] = dout1_a; dw[2] = dout0_b; dw[3] = dout1_b;
    rw[0] = rv0_a;   rw[1] = rv1_a;   rw[2] = rv0_b;   rw[3] = rv1_b;
    if (rst_edge.exists(n)) for (int p = 0; p < 4; p++) begin
      last_m[p] = '0; lastk_m[p] = 1'b1;
    end
    for (int p = 0; p < 4; p++) begin
      nm = $sformatf("%s%0d", (p < 2) ? "A" : "B", p % 2);
      idx = -1;
      for (int i = 0; i < sb.size(); i++) if (sb[i].port == p) begin idx = i; break; end
      if (rw[p]) begin
        if (idx < 0) chk({nm, " unexpected rvalid"}, {31'b0, rw[p]}, 32'd0);
        else begin
          chk({nm, " rvalid timing"}, n, sb[idx].due);
          if (!sb[idx].dc) chk({nm, " read data"}, dw[p], sb[idx].data);
          last_m[p]  = sb[idx].data;
          lastk_m[p] = !sb[idx].dc;
          sb.delete(idx);
        end
      end else begin
        if (idx >= 0 && sb[idx].due <= n) begin
          chk({nm, " missing rvalid"}, {31'b0, rw[p]}, 32'd1);
          sb.delete(idx);
        end
        if (lastk_m[p]) chk({nm, " held dout"}, dw[p], last_m[p]);
      end
    end
    chk("A collision", {31'b0, coll_a}, {31'b0, coll_exp.exists(n*2)});
    chk("B collision", {31'b0, coll_b}, {31'b0, coll_exp.exists(n*2+1)});
    if (busy_exp.exists(n*2))   chk("A init_busy", {31'b0, busy_a}, {31'b0, busy_exp[n*2]});
    if (busy_exp.exists(n*2+1)) chk("B init_busy", {31'b0, busy_b}, {31'b0, busy_exp[n*2+1]});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cnt;
    for (int k = 0; k < 2; k++) for (int a = 0; a < DEPTH; a++) begin
      mem_m[k][a] = '0; known_m[k][a] = 1'b0;
    end

    drive(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0);
    drive(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0);
    chk("A dout0 after reset", dout0_a, 32'h0);
    chk("A rvalid1 after reset", {31'b0, rv1_a}, 32'h0);

    // Seven clear cycles (addresses 0..6) with reads that A must ignore, then reset at address 7
    for (int i = 0; i < 7; i++)
      drive(1'b0, 1'b0, 1'b1, 4'h0, 4'($urandom), 32'h0, 1'b0, 4'($urandom));
    drive(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0);
    chk("A dout1 after mid-init reset", dout1_a, 32'h0);
    chk("B dout0 after mid-init reset", dout0_b, 32'h0);

    cnt = 0;
    while (busy_a && cnt < 40) begin
      cnt++;
      drive(1'b0, 1'b0, ($urandom % 2) == 1, 4'hF, 4'($urandom), $urandom, 1'b0, 4'($urandom));
    end
    chk("A init_busy width", cnt, 32'd16);

    for (int a = 0; a < DEPTH; a++)
      drive(1'b0, 1'b0, 1'b0, 4'hF, 4'(a), $urandom, ($urandom % 2) == 1, 4'($urandom));

    // Masked write merge
    drive(1'b0, 1'b0, 1'b0, 4'hF, 4'h1, 32'hDEADBEEF, 1'b1, 4'h0);
    drive(1'b0, 1'b0, 1'b0, 4'h5, 4'h1, 32'h11223344, 1'b1, 4'h0);
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h1, 32'h0, 1'b1, 4'h0);
    idle(); idle();

    // Back-to-back port-1 reads
    for (int a = 0; a < 8; a++) drive(1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 1'b0, 4'(a));
    idle(); idle();

    // Same-edge write/read collision
    drive(1'b0, 1'b0, 1'b0, 4'hF, 4'h2, 32'hAAAAAAAA, 1'b1, 4'h0);
    drive(1'b0, 1'b0, 1'b0, 4'h3, 4'h2, 32'h55555555, 1'b0, 4'h2);
    idle(); idle();

    // Read then hold through idle cycles; then both ports on one address
    drive(1'b0, 1'b0, 1'b0, 4'hF, 4'h3, 32'h12345678, 1'b1, 4'h0);
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h3, 32'h0, 1'b1, 4'h0);
    for (int i = 0; i < 5; i++) idle();
    drive(1'b0, 1'b0, 1'b1, 4'h0, 4'h5, 32'h0, 1'b0, 4'h5);
    idle(); idle();

    for (int i = 0; i < 400; i++) begin
      logic [3:0] a0;
      a0 = 4'($urandom);
      drive(1'b0, ($urandom % 4) == 0, ($urandom % 2) == 1, 4'($urandom), a0, $urandom,
            ($urandom % 4) == 0, (($urandom % 3) == 0) ? a0 : 4'($urandom));
    end
    idle(); idle(); idle();

    // Reset again: A re-clears, B keeps its contents
    drive(1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0);
    for (int i = 0; i < 17; i++) idle();
    for (int a = 0; a < DEPTH; a++)
      drive(1'b0, 1'b0, 1'b1, 4'h0, 4'(a), 32'h0, 1'b0, 4'(DEPTH-1-a));
    idle(); idle(); idle(); idle();
    chk("scoreboard drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
